// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data memory for the MEM stage of the MIPS pipeline with a memory-mapped I/O
// window. addr[31]=0 selects a word-addressed synchronous RAM; addr[31]=1
// selects the I/O window (input channels, output registers with write
// strobes, and a free-running 32-bit cycle counter). All reads, RAM or I/O,
// return one cycle after the address is presented.
//
// Ports:
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous active-high reset (RAM contents are not cleared)
//   we         write request for this cycle
//   be[3:0]    byte enables, be[i] gates wdata[8i+7:8i]
//   addr[31:0] byte address, bits [1:0] ignored
//   wdata      write data
//   rdata      registered read data for the previous cycle's addr
//   in_data    NUM_IN input channels, channel k = bits [k*IN_W +: IN_W]
//   out_data   NUM_OUT output registers, channel j = bits [j*OUT_W +: OUT_W]
//   out_strobe one-cycle pulse per output channel, the cycle after a write
// -----------------------------------------------------------------------------
module dmem_mmio #(
    parameter int ADDR_W  = 14,
    parameter int NUM_IN  = 2,
    parameter int IN_W    = 8,
    parameter int NUM_OUT = 1,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [3:0]                be,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    input  logic [NUM_IN*IN_W-1:0]    in_data,
    output logic [NUM_OUT*OUT_W-1:0]  out_data,
    output logic [NUM_OUT-1:0]        out_strobe
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [5:0] CNT_IDX = 6'd62;

    // Storage
    logic [31:0]                     mem_q [0:DEPTH-1];
    logic [NUM_OUT-1:0][OUT_W-1:0]   out_q;
    logic [NUM_OUT-1:0][OUT_W-1:0]   out_d;
    logic [NUM_OUT-1:0]              strobe_q;
    logic [NUM_OUT-1:0]              strobe_d;
    logic [31:0]                     cnt_q;
    logic [31:0]                     cnt_d;
    logic [31:0]                     rdata_q;

    // Address decode
    logic                            is_io_s;
    logic [5:0]                      idx_s;
    logic [ADDR_W-1:0]               ram_idx_s;
    logic [NUM_OUT-1:0]              out_hit_s;
    logic                            cnt_hit_s;
    logic [31:0]                     cnt_merge_s;
    logic [31:0]                     io_rdata_s;

    // Upper RAM-address bits alias and addr[1:0] is a byte offset; fold them
    // into a sink so every address bit is accounted for.
    logic                            unused_addr_s;
    assign unused_addr_s = ^addr;

    assign is_io_s   = addr[31];
    assign idx_s     = addr[7:2];
    assign ram_idx_s = addr[ADDR_W+1:2];
    assign cnt_hit_s = is_io_s && (idx_s == CNT_IDX);

    // Decode which output register (if any) the current address selects
    always_comb begin
        out_hit_s = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            out_hit_s[j] = is_io_s && (idx_s == 6'(32 + j));
        end
    end

    // I/O read mux: inputs at idx 0.., outputs at idx 32.., counter at 62
    always_comb begin
        io_rdata_s = 32'd0;
        for (int k = 0; k < NUM_IN; k++) begin
            io_rdata_s = (idx_s == 6'(k)) ? 32'(in_data[k*IN_W +: IN_W]) : io_rdata_s;
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            io_rdata_s = (idx_s == 6'(32 + j)) ? 32'(out_q[j]) : io_rdata_s;
        end
        if (idx_s == CNT_IDX) begin
            io_rdata_s = cnt_q;
        end else begin
            io_rdata_s = io_rdata_s;
        end
    end

    // Output register next state: only enabled bytes inside OUT_W change
    always_comb begin
        out_d = out_q;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int i = 0; i < OUT_W; i++) begin
                out_d[j][i] = (we && out_hit_s[j] && be[i/8]) ? wdata[i] : out_q[j][i];
            end
        end
    end

    // Strobe fires for any write hitting an output, even with be=0000
    always_comb begin
        if (we) begin
            strobe_d = out_hit_s;
        end else begin
            strobe_d = '0;
        end
    end

    // Counter next state: a write loads merged bytes and skips that increment
    always_comb begin
        cnt_merge_s = cnt_q;
        for (int b = 0; b < 4; b++) begin
            cnt_merge_s[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : cnt_q[b*8 +: 8];
        end
        if (we && cnt_hit_s) begin
            cnt_d = cnt_merge_s;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // RAM byte writes; not reset, and a write during rst still completes
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && !is_io_s && be[b]) begin
                mem_q[ram_idx_s][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // I/O state and read-data register; reads sample pre-edge values so
    // read-during-write returns the old contents
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            strobe_q <= '0;
            cnt_q    <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            rdata_q  <= is_io_s ? io_rdata_s : mem_q[ram_idx_s];
        end
    end

    assign rdata      = rdata_q;
    assign out_data   = out_q;
    assign out_strobe = strobe_q;

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic [0:0]  out_strobe;

    int vec_cnt;
    int miss_cnt;

    dmem_mmio #(
        .ADDR_W(14), .NUM_IN(2), .IN_W(8), .NUM_OUT(1), .OUT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata), .in_data(in_data), .out_data(out_data), .out_strobe(out_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge; inputs may be changed and outputs sampled afterwards
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] a);
        we = 1'b0; be = 4'h0; wdata = 32'h0; addr = a;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; be = b; wdata = d; addr = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(32'h0);
        in_data = 16'h0;
        step(); step();
        rst = 1'b0;
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
        vec_cnt++;
        if (out_data !== 16'h0) begin miss_cnt++; $display("FAIL reset_out got %h exp %h", out_data, 16'h0); end
        vec_cnt++;
        if (out_strobe !== 1'b0) begin miss_cnt++; $display("FAIL reset_strobe got %b exp %b", out_strobe, 1'b0); end
        // now in cycle 0 after reset; counter reads 5 when addressed in cycle 5
        for (int i = 0; i < 5; i++) step();
        addr = 32'h8000_00F8;
        step();
        vec_cnt++;
        if (rdata !== 32'd5) begin miss_cnt++; $display("FAIL cnt_after_reset got %h exp %h", rdata, 32'd5); end
    endtask

    task automatic test_ram_be();
        wr(32'h0000_0010, 32'h1122_3344, 4'b1111); step();
        wr(32'h0000_0010, 32'hAABB_CCDD, 4'b0101); step();
        idle(32'h0000_0010); step();
        vec_cnt++;
        if (rdata !== 32'h11BB_33DD) begin miss_cnt++; $display("FAIL ram_be got %h exp %h", rdata, 32'h11BB_33DD); end
        idle(32'h0001_0010); step();
        vec_cnt++;
        if (rdata !== 32'h11BB_33DD) begin miss_cnt++; $display("FAIL ram_alias got %h exp %h", rdata, 32'h11BB_33DD); end
    endtask

    task automatic test_rdw();
        wr(32'h0000_0020, 32'h0, 4'b1111); step();
        wr(32'h0000_0020, 32'h55, 4'b1111); step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL ram_rdw_old got %h exp %h", rdata, 32'h0); end
        idle(32'h0000_0020); step();
        vec_cnt++;
        if (rdata !== 32'h55) begin miss_cnt++; $display("FAIL ram_rdw_new got %h exp %h", rdata, 32'h55); end
    endtask

    task automatic test_inputs();
        in_data = {8'hA5, 8'h3C};
        idle(32'h8000_0000); step();
        vec_cnt++;
        if (rdata !== 32'h3C) begin miss_cnt++; $display("FAIL in0 got %h exp %h", rdata, 32'h3C); end
        idle(32'h8000_0004); step();
        vec_cnt++;
        if (rdata !== 32'hA5) begin miss_cnt++; $display("FAIL in1 got %h exp %h", rdata, 32'hA5); end
        idle(32'h8000_0008); step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL in_unmapped got %h exp %h", rdata, 32'h0); end
        wr(32'h8000_1200, 32'hFFFF_FFFF, 4'b1111); step();
        vec_cnt++;
        if (rdata !== 32'h3C) begin miss_cnt++; $display("FAIL in0_alias got %h exp %h", rdata, 32'h3C); end
        idle(32'h8000_0000); step();
        vec_cnt++;
        if (rdata !== 32'h3C) begin miss_cnt++; $display("FAIL in_ro got %h exp %h", rdata, 32'h3C); end
        idle(32'h8000_00FC); step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL idx63 got %h exp %h", rdata, 32'h0); end
    endtask

    task automatic test_out();
        wr(32'h8000_0080, 32'h1234_ABCD, 4'b1111); step();
        vec_cnt++;
        if (out_data !== 16'hABCD) begin miss_cnt++; $display("FAIL out_full got %h exp %h", out_data, 16'hABCD); end
        vec_cnt++;
        if (out_strobe !== 1'b1) begin miss_cnt++; $display("FAIL out_strobe_hi got %b exp %b", out_strobe, 1'b1); end
        idle(32'h8000_0080); step();
        vec_cnt++;
        if (out_strobe !== 1'b0) begin miss_cnt++; $display("FAIL out_strobe_lo got %b exp %b", out_strobe, 1'b0); end
        vec_cnt++;
        if (rdata !== 32'h0000_ABCD) begin miss_cnt++; $display("FAIL out_readback got %h exp %h", rdata, 32'h0000_ABCD); end
        // byte 1 write; also a read-during-write which must return the old value
        wr(32'h8000_0080, 32'h0000_7700, 4'b0010); step();
        vec_cnt++;
        if (out_data !== 16'h77CD) begin miss_cnt++; $display("FAIL out_byte1 got %h exp %h", out_data, 16'h77CD); end
        vec_cnt++;
        if (rdata !== 32'h0000_ABCD) begin miss_cnt++; $display("FAIL out_rdw got %h exp %h", rdata, 32'h0000_ABCD); end
        // be=0000 and a byte outside OUT_W: data unchanged, strobes back-to-back
        wr(32'h8000_0080, 32'h0000_0000, 4'b0000); step();
        vec_cnt++;
        if (out_strobe !== 1'b1) begin miss_cnt++; $display("FAIL out_strobe_be0 got %b exp %b", out_strobe, 1'b1); end
        wr(32'h8000_0080, 32'h0099_0000, 4'b0100); step();
        vec_cnt++;
        if (out_strobe !== 1'b1) begin miss_cnt++; $display("FAIL out_strobe_b2b got %b exp %b", out_strobe, 1'b1); end
        vec_cnt++;
        if (out_data !== 16'h77CD) begin miss_cnt++; $display("FAIL out_unchanged got %h exp %h", out_data, 16'h77CD); end
        wr(32'h8000_0084, 32'hFFFF_FFFF, 4'b1111); step();
        vec_cnt++;
        if (out_strobe !== 1'b0) begin miss_cnt++; $display("FAIL out_strobe_unmapped got %b exp %b", out_strobe, 1'b0); end
        idle(32'h8000_0084); step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL idx33 got %h exp %h", rdata, 32'h0); end
    endtask

    task automatic test_counter();
        wr(32'h8000_00F8, 32'hFFFF_FFFF, 4'b1111); step();
        idle(32'h8000_00F8); step();
        vec_cnt++;
        if (rdata !== 32'hFFFF_FFFF) begin miss_cnt++; $display("FAIL cnt_load got %h exp %h", rdata, 32'hFFFF_FFFF); end
        step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL cnt_wrap got %h exp %h", rdata, 32'h0); end
        // counter is 1 now; merge byte 1 and read it in the same cycle
        wr(32'h8000_00F8, 32'h0000_1200, 4'b0010); step();
        vec_cnt++;
        if (rdata !== 32'h1) begin miss_cnt++; $display("FAIL cnt_rdw got %h exp %h", rdata, 32'h1); end
        idle(32'h8000_00F8); step();
        vec_cnt++;
        if (rdata !== 32'h1201) begin miss_cnt++; $display("FAIL cnt_merge got %h exp %h", rdata, 32'h1201); end
        step();
        vec_cnt++;
        if (rdata !== 32'h1202) begin miss_cnt++; $display("FAIL cnt_resume got %h exp %h", rdata, 32'h1202); end
    endtask

    task automatic test_reset_mid();
        wr(32'h0000_0040, 32'hCAFE_F00D, 4'b1111); step();
        wr(32'h8000_0080, 32'h0000_BEEF, 4'b0011); step();
        wr(32'h8000_00F8, 32'd100, 4'b1111); step();
        idle(32'h8000_00F8); step();
        vec_cnt++;
        if (rdata !== 32'd100) begin miss_cnt++; $display("FAIL mid_cnt_pre got %h exp %h", rdata, 32'd100); end
        rst = 1'b1;
        wr(32'h8000_0080, 32'h0000_1111, 4'b1111); step();
        rst = 1'b0;
        idle(32'h8000_00F8);
        vec_cnt++;
        if (out_data !== 16'h0) begin miss_cnt++; $display("FAIL mid_out got %h exp %h", out_data, 16'h0); end
        vec_cnt++;
        if (out_strobe !== 1'b0) begin miss_cnt++; $display("FAIL mid_strobe got %b exp %b", out_strobe, 1'b0); end
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL mid_rdata got %h exp %h", rdata, 32'h0); end
        step();
        vec_cnt++;
        if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL mid_cnt got %h exp %h", rdata, 32'h0); end
        vec_cnt++;
        if (out_strobe !== 1'b0) begin miss_cnt++; $display("FAIL mid_strobe2 got %b exp %b", out_strobe, 1'b0); end
        idle(32'h0000_0040); step();
        vec_cnt++;
        if (rdata !== 32'hCAFE_F00D) begin miss_cnt++; $display("FAIL mid_ram got %h exp %h", rdata, 32'hCAFE_F00D); end
        // a RAM write issued while rst is high still lands
        rst = 1'b1;
        wr(32'h0000_0044, 32'h5A5A_5A5A, 4'b1111); step();
        rst = 1'b0;
        idle(32'h0000_0044); step();
        vec_cnt++;
        if (rdata !== 32'h5A5A_5A5A) begin miss_cnt++; $display("FAIL rst_ram_wr got %h exp %h", rdata, 32'h5A5A_5A5A); end
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        test_reset();
        test_ram_be();
        test_rdw();
        test_inputs();
        test_out();
        test_counter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
